hazard_scoreboard: RTL

//  Parametrised Tuse/Tnew hazard unit for the 5-stage core; replaces static compare-only forwarding.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: shadow E/M/W pipe of {dest, tnew, rs, rt}, D-stage stall,
// D/E/M bypass selects and a mult/div busy counter interlocking HI/LO users.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int FWD_EN  = 1,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [AW-1:0] dest_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          wen_d,
  input  logic          md_op_d,
  input  logic          md_div_d,
  input  logic          md_use_d,
  input  logic          flush_e,
  output logic          stall_d,
  output logic [1:0]    fsel_rs_d,
  output logic [1:0]    fsel_rt_d,
  output logic [1:0]    fsel_rs_e,
  output logic [1:0]    fsel_rt_e,
  output logic          fsel_rt_m,
  output logic          md_busy
);

  localparam bit FWD    = (FWD_EN != 0);
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Shadow pipe state
  logic          e_live_q, m_live_q, w_live_q;
  logic [AW-1:0] e_dest_q, e_rs_q, e_rt_q, m_dest_q, m_rt_q, w_dest_q;
  logic [TW-1:0] e_tnew_q, m_tnew_q, w_tnew_q;

  // Mult/div tracking
  logic          md_start_q, md_div_q;
  logic [CW-1:0] cnt_q;

  logic          adv;
  logic          md_stall;
  logic [1:0]    stall_src;
  logic [1:0][AW-1:0] src_d, src_e;
  logic [1:0][TW-1:0] tuse_d;
  logic [1:0][1:0]    sel_d, sel_e;

  assign src_d  = {rt_d, rs_d};
  assign tuse_d = {tuse_rt_d, tuse_rs_d};
  assign src_e  = {e_rt_q, e_rs_q};

  // D stage: youngest live match decides both the stall and the bypass source.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stall_src[i] = 1'b0;
      sel_d[i]     = 2'd0;
      if (src_d[i] != '0) begin
        if (e_live_q && e_dest_q == src_d[i]) begin
          stall_src[i] = FWD ? (e_tnew_q > tuse_d[i]) : 1'b1;
          if (e_tnew_q == '0) sel_d[i] = 2'd1;
        end else if (m_live_q && m_dest_q == src_d[i]) begin
          stall_src[i] = FWD ? (m_tnew_q > tuse_d[i]) : 1'b1;
          if (m_tnew_q == '0) sel_d[i] = 2'd2;
        end else if (w_live_q && w_dest_q == src_d[i]) begin
          // Without bypassing, the write-first RF already covers W.
          stall_src[i] = FWD ? (w_tnew_q > tuse_d[i]) : 1'b0;
          if (w_tnew_q == '0) sel_d[i] = 2'd3;
        end
      end
      if (!FWD) sel_d[i] = 2'd0;
    end
  end

  // E stage: a not-yet-ready M producer shadows any older W copy.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sel_e[i] = 2'd0;
      if (src_e[i] != '0) begin
        if (m_live_q && m_dest_q == src_e[i]) begin
          if (m_tnew_q == '0) sel_e[i] = 2'd1;
        end else if (w_live_q && w_dest_q == src_e[i] && w_tnew_q == '0) begin
          sel_e[i] = 2'd2;
        end
      end
      if (!FWD) sel_e[i] = 2'd0;
    end
  end

  assign md_busy   = md_start_q | (cnt_q != '0);
  assign md_stall  = md_use_d & md_busy;
  assign stall_d   = |stall_src | md_stall;
  assign adv       = !stall_d && !flush_e;

  assign fsel_rs_d = sel_d[0];
  assign fsel_rt_d = sel_d[1];
  assign fsel_rs_e = sel_e[0];
  assign fsel_rt_e = sel_e[1];
  assign fsel_rt_m = FWD && w_live_q && (w_dest_q == m_rt_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_live_q   <= 1'b0;
      m_live_q   <= 1'b0;
      w_live_q   <= 1'b0;
      md_start_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      e_live_q   <= adv && wen_d && (dest_d != '0);
      m_live_q   <= e_live_q;
      w_live_q   <= m_live_q;
      md_start_q <= adv && md_op_d;
      if (md_start_q)
        cnt_q <= md_div_q ? CW'(DIV_LAT) : CW'(MUL_LAT);
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  // NOTE: payload fields carry no reset; the live bits above gate every use of them.
  // A bubble is loaded as an all-zero entry so register 0 keeps it from matching.
  always_ff @(posedge clk) begin
    e_dest_q <= adv ? dest_d : '0;
    e_tnew_q <= adv ? tnew_d : '0;
    e_rs_q   <= adv ? rs_d   : '0;
    e_rt_q   <= adv ? rt_d   : '0;
    m_dest_q <= e_dest_q;
    m_tnew_q <= sat_dec(e_tnew_q);
    m_rt_q   <= e_rt_q;
    w_dest_q <= m_dest_q;
    w_tnew_q <= sat_dec(m_tnew_q);
    md_div_q <= md_div_d;
  end

endmodule
